// File: rtl/oka_operand_split_15bit_if.sv
// Operand/sub-product bus for the 15-bit OKA operand splitter.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; once valid is raised the payload holds steady and valid stays high
// until that transfer (reset is the only exception).
interface oka_operand_split_15bit_if #(
  parameter int N = 16
);
  localparam int HW = N / 2;

  logic          in_valid;
  logic          in_ready;
  logic [N-2:0]  in_a;
  logic [N-2:0]  in_b;
  logic          sub_valid;
  logic          sub_ready;
  logic [HW-1:0] sub_x;
  logic [HW-1:0] sub_y;
  logic [1:0]    sub_tag;
  logic          sub_last;

  // Upstream producer and downstream sub-multiplier side
  modport master (
    output in_valid, in_a, in_b, sub_ready,
    input  in_ready, sub_valid, sub_x, sub_y, sub_tag, sub_last
  );

  // Splitter side
  modport slave (
    input  in_valid, in_a, in_b, sub_ready,
    output in_ready, sub_valid, sub_x, sub_y, sub_tag, sub_last
  );
endinterface

// File: rtl/oka_operand_split_15bit.sv
// Operand splitter/dispatcher for the 15-bit OKA GF(2) multiplier stage.
// Splits each operand into even/odd coefficient halves and issues the
// sub-product operand pairs one per handshake, tagged for recombination.
// Build option: define OKA_SPLIT_KARATSUBA_EN to issue the three Karatsuba
// products (tags 0, 3, 2) instead of the four schoolbook products (0, 1, 2, 3).
module oka_operand_split_15bit #(
  parameter int N = 16
) (
  input  logic clk,
  input  logic rst,
  oka_operand_split_15bit_if.slave bus,
  output logic busy,
  output logic dbg_state
);
  localparam int HW = N / 2;
  localparam int W  = N - 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [HW-1:0] ae, ao, be, bo;

  logic [1:0]    nxt_idx;
  logic [HW-1:0] nxt_x, nxt_y;
  logic [1:0]    nxt_tag;
  logic          nxt_last;

  // Coefficients of x^0, x^2, ... x^14
  function automatic logic [HW-1:0] even_half(input logic [W-1:0] v);
    logic [HW-1:0] r;
    for (int i = 0; i < HW; i++) r[i] = v[2*i];
    return r;
  endfunction

  // Coefficients of x^1, x^3, ... x^13; top bit padded with 0
  function automatic logic [HW-1:0] odd_half(input logic [W-1:0] v);
    logic [HW-1:0] r;
    for (int i = 0; i < HW - 1; i++) r[i] = v[2*i+1];
    r[HW-1] = 1'b0;
    return r;
  endfunction

  assign dbg_state    = state;
  assign bus.in_ready = (state == IDLE) && !rst;

  // Payload of the product that follows the current one
  always_comb begin
    nxt_idx  = idx + 2'd1;
    nxt_x    = '0;
    nxt_y    = '0;
    nxt_tag  = 2'd0;
    nxt_last = 1'b0;
`ifdef OKA_SPLIT_KARATSUBA_EN
    case (nxt_idx)
      2'd1:    begin nxt_x = ao;      nxt_y = bo;      nxt_tag = 2'd3; end
      default: begin nxt_x = ae ^ ao; nxt_y = be ^ bo; nxt_tag = 2'd2; nxt_last = 1'b1; end
    endcase
`else
    case (nxt_idx)
      2'd1:    begin nxt_x = ae; nxt_y = bo; nxt_tag = 2'd1; end
      2'd2:    begin nxt_x = ao; nxt_y = be; nxt_tag = 2'd2; end
      default: begin nxt_x = ao; nxt_y = bo; nxt_tag = 2'd3; nxt_last = 1'b1; end
    endcase
`endif
  end

  // Capture operands, then walk the product index one handshake at a time
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 2'd0;
      ae            <= '0;
      ao            <= '0;
      be            <= '0;
      bo            <= '0;
      bus.sub_valid <= 1'b0;
      bus.sub_x     <= '0;
      bus.sub_y     <= '0;
      bus.sub_tag   <= 2'd0;
      bus.sub_last  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ae            <= even_half(bus.in_a);
            ao            <= odd_half(bus.in_a);
            be            <= even_half(bus.in_b);
            bo            <= odd_half(bus.in_b);
            idx           <= 2'd0;
            state         <= ISSUE;
            busy          <= 1'b1;
            // First product is always Ae*Be in both build options
            bus.sub_valid <= 1'b1;
            bus.sub_x     <= even_half(bus.in_a);
            bus.sub_y     <= even_half(bus.in_b);
            bus.sub_tag   <= 2'd0;
            bus.sub_last  <= 1'b0;
          end
        end
        ISSUE: begin
          if (bus.sub_ready) begin
            if (bus.sub_last) begin
              state         <= IDLE;
              idx           <= 2'd0;
              busy          <= 1'b0;
              bus.sub_valid <= 1'b0;
              bus.sub_x     <= '0;
              bus.sub_y     <= '0;
              bus.sub_tag   <= 2'd0;
              bus.sub_last  <= 1'b0;
            end else begin
              idx           <= nxt_idx;
              bus.sub_x     <= nxt_x;
              bus.sub_y     <= nxt_y;
              bus.sub_tag   <= nxt_tag;
              bus.sub_last  <= nxt_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oka_operand_split_15bit.sv
// Bench for oka_operand_split_15bit: table vectors, hand-written stall,
// back-to-back and reset sequences, then randomized pairs against a model.
module tb_oka_operand_split_15bit;
`ifdef OKA_SPLIT_KARATSUBA_EN
  localparam int PERIOD = 4;
`else
  localparam int PERIOD = 5;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic dbg_state;

  oka_operand_split_15bit_if #(.N(16)) bus ();

  oka_operand_split_15bit #(.N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // {x[7:0], y[7:0], tag[1:0], last}
  logic [18:0] exp_q[$];

  typedef struct {
    logic [14:0] a;
    logic [14:0] b;
    logic [7:0]  ae, ao, be, bo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: coefficient extraction by plain arithmetic
  function automatic logic [7:0] half_of(input logic [14:0] v, input int odd);
    int r = 0;
    for (int i = 0; i < 8; i++)
      if (2*i + odd < 15) r += ((int'(v) >> (2*i + odd)) & 1) << i;
    return 8'(r);
  endfunction

  task automatic push_halves(input logic [7:0] ae, ao, be, bo);
`ifdef OKA_SPLIT_KARATSUBA_EN
    exp_q.push_back({ae, be, 2'd0, 1'b0});
    exp_q.push_back({ao, bo, 2'd3, 1'b0});
    exp_q.push_back({ae ^ ao, be ^ bo, 2'd2, 1'b1});
`else
    exp_q.push_back({ae, be, 2'd0, 1'b0});
    exp_q.push_back({ae, bo, 2'd1, 1'b0});
    exp_q.push_back({ao, be, 2'd2, 1'b0});
    exp_q.push_back({ao, bo, 2'd3, 1'b1});
`endif
  endtask

  task automatic push_model(input logic [14:0] a, input logic [14:0] b);
    push_halves(half_of(a, 0), half_of(a, 1), half_of(b, 0), half_of(b, 1));
  endtask

  function automatic logic [18:0] payload();
    return {bus.sub_x, bus.sub_y, bus.sub_tag, bus.sub_last};
  endfunction

  // Offer one operand pair; called #1 after a clock edge
  task automatic run_pair(input logic [14:0] a, input logic [14:0] b);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Consume every queued product with random back-pressure
  task automatic drain(input int stall_pct);
    logic [18:0] item;
    int waited;
    bit hs;
    while (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      hs = 1'b0; waited = 0;
      while (!hs && waited < 40) begin
        bus.sub_ready = ($urandom_range(0, 99) >= stall_pct);
        check("sub_valid", 32'(bus.sub_valid), 32'd1);
        check("payload", 32'(payload()), 32'(item));
        check("in_ready_issue", 32'(bus.in_ready), 32'd0);
        hs = bus.sub_ready && bus.sub_valid;
        @(posedge clk); #1; waited++;
      end
      if (!hs) begin
        checks++; failures++;
        $display("FAIL drain_timeout: no handshake for item %0h", item);
      end
    end
    bus.sub_ready = 1'b0;
    check("idle_sub_valid", 32'(bus.sub_valid), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    logic [18:0] item;
    int acc_cyc[3];
    int acc;

    vecs[0] = '{15'h7FFF, 15'h0001, 8'hFF, 8'h7F, 8'h01, 8'h00};
    vecs[1] = '{15'h5555, 15'h2AAA, 8'hFF, 8'h00, 8'h00, 8'h7F};
    vecs[2] = '{15'h0000, 15'h7FFF, 8'h00, 8'h00, 8'hFF, 8'h7F};
    vecs[3] = '{15'h1234, 15'h0003, 8'h46, 8'h14, 8'h01, 8'h01};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.sub_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sub_valid", 32'(bus.sub_valid), 32'd0);
    check("rst_sub_xy", 32'({bus.sub_x, bus.sub_y}), 32'd0);
    check("rst_tag_last", 32'({bus.sub_tag, bus.sub_last}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table vectors, sub_ready held high
    for (int v = 0; v < 4; v++) begin
      push_halves(vecs[v].ae, vecs[v].ao, vecs[v].be, vecs[v].bo);
      run_pair(vecs[v].a, vecs[v].b);
      drain(0);
    end

    // Stall three cycles on the second product
    push_model(15'h7FFF, 15'h0001);
    run_pair(15'h7FFF, 15'h0001);
    bus.sub_ready = 1'b1;
    check("stall_p0", 32'(payload()), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    bus.sub_ready = 1'b0;
    item = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", 32'(payload()), 32'(item));
      check("stall_valid", 32'(bus.sub_valid), 32'd1);
      @(posedge clk); #1;
    end
    bus.sub_ready = 1'b1;
    check("stall_release", 32'(payload()), 32'(item));
    @(posedge clk); #1;
    check("stall_next", 32'(payload()), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    drain(0);

    // Back-to-back pairs with in_valid held high
    acc = 0;
    bus.sub_ready = 1'b1;
    bus.in_a = 15'($urandom); bus.in_b = 15'($urandom); bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 3 * PERIOD; cyc++) begin
      if (bus.sub_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b2b_extra: unexpected product %0h", payload());
        end else check("b2b_payload", 32'(payload()), 32'(exp_q.pop_front()));
      end
      check("b2b_ready_vs_valid", 32'(bus.in_ready), 32'(!bus.sub_valid));
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc[acc] = cyc; acc++;
        push_model(bus.in_a, bus.in_b);
      end
      @(posedge clk); #1;
      if (acc == 3) bus.in_valid = 1'b0;
      else begin bus.in_a = 15'($urandom); bus.in_b = 15'($urandom); end
    end
    check("b2b_accepts", 32'(acc), 32'd3);
    check("b2b_period1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(PERIOD));
    check("b2b_period2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(PERIOD));
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    drain(0);

    // Reset while the third product (tag 2) is presented
    push_model(15'h1234, 15'h0003);
    run_pair(15'h1234, 15'h0003);
    bus.sub_ready = 1'b1;
    check("rstseq_p0", 32'(payload()), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    check("rstseq_p1", 32'(payload()), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    check("rstseq_p2", 32'(payload()), 32'(exp_q.pop_front()));
    check("rstseq_tag2", 32'(bus.sub_tag), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstseq_sub_valid", 32'(bus.sub_valid), 32'd0);
    check("rstseq_busy", 32'(busy), 32'd0);
    check("rstseq_in_ready_low", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    bus.sub_ready = 1'b0;
    exp_q.delete();
    #1;
    check("rstseq_in_ready", 32'(bus.in_ready), 32'd1);
    push_model(15'h7FFF, 15'h0001);
    run_pair(15'h7FFF, 15'h0001);
    check("rstseq_restart_tag0", 32'(bus.sub_tag), 32'd0);
    drain(0);

    // Randomized pairs with random back-pressure
    for (int r = 0; r < 25; r++) begin
      logic [14:0] ra, rb;
      ra = 15'($urandom); rb = 15'($urandom);
      push_model(ra, rb);
      run_pair(ra, rb);
      drain(30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
